// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the memory-port arbiter and the cache blocks that
// will sit on top of it: the arbiter state encoding and the helper that
// sizes a port-index field from a port count.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Width of an index able to address n ports, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_grant_sel.sv
// arb_grant_sel
// Purely combinational grant selector. Picks one active requester either by
// fixed priority (lowest index wins) or round-robin (search begins at
// rr_ptr and wraps modulo NUM_PORTS).
// Ports:
//   active      in   NUM_PORTS  per-port request present
//   rr_ptr      in   IDX_W      round-robin search start (ignored in fixed mode)
//   grant       out  IDX_W      index of the selected port
//   grant_valid out  1          at least one port is active
module arb_grant_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int RR_MODE   = 0,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] active,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     grant,
  output logic                 grant_valid
);

  int start;
  int idx;

  // Walk the ports in search order and take the first active one. In fixed
  // mode the search always starts at port 0, which gives lowest-index
  // priority. rr_ptr is always kept below NUM_PORTS, so one subtraction is
  // enough to wrap.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    start       = (RR_MODE != 0) ? int'(rr_ptr) : 0;
    idx         = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = start + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!grant_valid && active[idx]) begin
        grant_valid = 1'b1;
        grant       = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Clocked arbiter placing NUM_PORTS cache-side requesters (port 0 = data
// cache, port 1 = instruction cache) onto a single main-memory port. The
// winning command is latched and held on the memory side until mem_ready;
// the winner alone then receives a one-cycle ready pulse together with the
// registered read data.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   req_rd / req_wr       per-port level requests, held until that port's ready
//   req_addr / req_wdata  flattened per-port address / write data
//   rdata                 registered read data, valid with ready
//   ready                 one-hot, one-cycle completion pulse
//   mem_rd / mem_wr       memory strobes
//   mem_addr / mem_wdata  memory command
//   mem_rdata / mem_ready memory read data and single-cycle completion
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_rd,
  input  logic [NUM_PORTS-1:0]          req_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_PORTS-1:0]          ready,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ready
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  arb_state_t           state;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_sel;
  logic                 grant_valid;
  logic [NUM_PORTS-1:0] active;

  // A port with both strobes set still counts once; it is treated as a write.
  assign active = req_rd | req_wr;

  arb_grant_sel #(
    .NUM_PORTS (NUM_PORTS),
    .RR_MODE   (RR_MODE),
    .IDX_W     (IDX_W)
  ) u_grant_sel (
    .active      (active),
    .rr_ptr      (rr_ptr),
    .grant       (grant_sel),
    .grant_valid (grant_valid)
  );

  // Arbiter FSM with registered memory-side command and requester-side
  // response. Requests are only looked at in IDLE, so anything a requester
  // does while its command is in flight has no effect. mem_ready only
  // matters in BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      rr_ptr    <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      ready     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= '0;
          if (grant_valid) begin
            grant_q   <= grant_sel;
            mem_wr    <= req_wr[grant_sel];
            mem_rd    <= ~req_wr[grant_sel];
            mem_addr  <= req_addr[int'(grant_sel)*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[int'(grant_sel)*DATA_W +: DATA_W];
            rr_ptr    <= (grant_sel == IDX_W'(NUM_PORTS-1)) ? '0
                                                             : grant_sel + IDX_W'(1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (mem_rd) rdata <= mem_rdata;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            ready  <= ONE_HOT0 << grant_q;
            state  <= DONE;
          end
        end
        DONE: begin
          ready <= '0;
          state <= IDLE;
        end
        default: begin
          ready <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Two instances are exercised: a
// two-port fixed-priority arbiter and a four-port round-robin arbiter. A
// transaction-level reference model (requesters holding commands, a memory
// answering after a chosen number of wait cycles, and a grant choice made
// by distance from the round-robin pointer) predicts every output.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus, steered to the selected instance (0 = fixed, 1 = rr).
  logic        sel = 1'b0;
  logic [3:0]  c_req_rd = '0;
  logic [3:0]  c_req_wr = '0;
  logic [31:0] c_addr [4];
  logic [31:0] c_wdata [4];
  logic        c_mem_ready = 1'b0;
  logic [31:0] c_mem_rdata = '0;

  logic [1:0]   fp_req_rd, fp_req_wr, fp_ready;
  logic [63:0]  fp_req_addr, fp_req_wdata;
  logic [31:0]  fp_rdata, fp_mem_addr, fp_mem_wdata;
  logic         fp_mem_rd, fp_mem_wr, fp_mem_ready;
  logic [3:0]   rr_req_rd, rr_req_wr, rr_ready;
  logic [127:0] rr_req_addr, rr_req_wdata;
  logic [31:0]  rr_rdata, rr_mem_addr, rr_mem_wdata;
  logic         rr_mem_rd, rr_mem_wr, rr_mem_ready;

  assign fp_req_rd    = sel ? 2'b00 : c_req_rd[1:0];
  assign fp_req_wr    = sel ? 2'b00 : c_req_wr[1:0];
  assign fp_req_addr  = sel ? 64'd0 : {c_addr[1], c_addr[0]};
  assign fp_req_wdata = sel ? 64'd0 : {c_wdata[1], c_wdata[0]};
  assign fp_mem_ready = sel ? 1'b0 : c_mem_ready;
  assign rr_req_rd    = sel ? c_req_rd : 4'b0000;
  assign rr_req_wr    = sel ? c_req_wr : 4'b0000;
  assign rr_req_addr  = sel ? {c_addr[3], c_addr[2], c_addr[1], c_addr[0]} : 128'd0;
  assign rr_req_wdata = sel ? {c_wdata[3], c_wdata[2], c_wdata[1], c_wdata[0]} : 128'd0;
  assign rr_mem_ready = sel ? c_mem_ready : 1'b0;

  logic [3:0]  s_ready;
  logic [31:0] s_rdata, s_mem_addr, s_mem_wdata;
  logic        s_mem_rd, s_mem_wr;
  assign s_ready     = sel ? rr_ready : {2'b00, fp_ready};
  assign s_rdata     = sel ? rr_rdata : fp_rdata;
  assign s_mem_rd    = sel ? rr_mem_rd : fp_mem_rd;
  assign s_mem_wr    = sel ? rr_mem_wr : fp_mem_wr;
  assign s_mem_addr  = sel ? rr_mem_addr : fp_mem_addr;
  assign s_mem_wdata = sel ? rr_mem_wdata : fp_mem_wdata;

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .req_rd(fp_req_rd), .req_wr(fp_req_wr),
    .req_addr(fp_req_addr), .req_wdata(fp_req_wdata), .rdata(fp_rdata),
    .ready(fp_ready), .mem_rd(fp_mem_rd), .mem_wr(fp_mem_wr),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_rdata(c_mem_rdata), .mem_ready(fp_mem_ready)
  );

  mem_port_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .req_rd(rr_req_rd), .req_wr(rr_req_wr),
    .req_addr(rr_req_addr), .req_wdata(rr_req_wdata), .rdata(rr_rdata),
    .ready(rr_ready), .mem_rd(rr_mem_rd), .mem_wr(rr_mem_wr),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
    .mem_rdata(c_mem_rdata), .mem_ready(rr_mem_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Requester model: op bit0 = read, bit1 = write, 0 = no request.
  logic [1:0]  p_op [4];
  logic [31:0] p_addr [4];
  logic [31:0] p_wdata [4];

  // Knobs for the cycle engine.
  int          nports = 2;
  bit          rr = 1'b0;
  logic [3:0]  issue_mask = '0;
  int          issue_prob = 0;
  int          wait_cfg = 0;
  bit          spurious = 1'b0;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;
  int          grant_log [$];
  int          rd_high = 0;
  int          wr_high = 0;

  // Reference view of the memory transaction in flight.
  int          m_phase = 0;   // 0 free, 1 waiting on memory, 2 completing
  int          m_win = 0;
  int          m_ptr = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          wait_left = 0;
  logic [3:0]  exp_ready = '0;
  logic [31:0] exp_rdata = '0;
  bit          exp_rd = 1'b0;
  bit          exp_wr = 1'b0;

  // Winner = active port at the smallest distance from the search start.
  function automatic int pick(input logic [3:0] act, input int n, input bit use_rr,
                              input int ptr);
    int best = -1;
    int bestd = 99;
    int d;
    for (int p = 0; p < n; p++) begin
      if (act[p]) begin
        d = use_rr ? (p - ptr + n) % n : p;
        if (d < bestd) begin
          bestd = d;
          best = p;
        end
      end
    end
    return best;
  endfunction

  task automatic drive_reqs();
    for (int p = 0; p < 4; p++) begin
      c_req_rd[p] = p_op[p][0];
      c_req_wr[p] = p_op[p][1];
      c_addr[p]   = p_addr[p];
      c_wdata[p]  = p_wdata[p];
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      p_op[p] = 2'b00;
      p_addr[p] = '0;
      p_wdata[p] = '0;
    end
    m_phase = 0; m_ptr = 0; m_win = 0; m_wr = 1'b0;
    exp_ready = '0; exp_rdata = '0; exp_rd = 1'b0; exp_wr = 1'b0;
    grant_log.delete();
    rd_high = 0; wr_high = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    drive_reqs();
    c_mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One negedge per cycle: compare outputs from the last edge, then choose
  // inputs for the next edge and advance the reference model.
  task automatic run(input int cycles);
    logic [3:0] act;
    logic [3:0] one;
    int w;
    one = 4'b0001;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_checks++;
      if (s_ready !== exp_ready) begin
        n_errors++;
        $display("[TB] FAIL ready: got %b expected %b at %0t", s_ready, exp_ready, $time);
      end
      n_checks++;
      if (s_rdata !== exp_rdata) begin
        n_errors++;
        $display("[TB] FAIL rdata: got %h expected %h at %0t", s_rdata, exp_rdata, $time);
      end
      n_checks++;
      if ({s_mem_rd, s_mem_wr} !== {exp_rd, exp_wr}) begin
        n_errors++;
        $display("[TB] FAIL strobes: got rd=%b wr=%b expected rd=%b wr=%b at %0t",
                 s_mem_rd, s_mem_wr, exp_rd, exp_wr, $time);
      end
      if (m_phase == 1) begin
        n_checks++;
        if (s_mem_addr !== m_addr || s_mem_wdata !== m_wdata) begin
          n_errors++;
          $display("[TB] FAIL command: got addr=%h wdata=%h expected addr=%h wdata=%h at %0t",
                   s_mem_addr, s_mem_wdata, m_addr, m_wdata, $time);
        end
      end
      if (s_mem_rd === 1'b1) rd_high++;
      if (s_mem_wr === 1'b1) wr_high++;

      for (int p = 0; p < nports; p++) begin
        if (exp_ready[p]) p_op[p] = 2'b00;
        if (p_op[p] == 2'b00 && issue_mask[p] && int'($urandom_range(99)) < issue_prob) begin
          p_op[p]    = 2'($urandom_range(1, 3));
          p_addr[p]  = $urandom;
          p_wdata[p] = $urandom;
        end
      end
      drive_reqs();

      c_mem_ready = 1'b0;
      if (m_phase == 1) begin
        if (wait_left == 0) begin
          c_mem_ready = 1'b1;
          c_mem_rdata = fixed_en ? fixed_data : $urandom;
        end else begin
          wait_left--;
        end
      end else if (spurious && $urandom_range(3) == 0) begin
        c_mem_ready = 1'b1;
        c_mem_rdata = $urandom;
      end

      case (m_phase)
        0: begin
          act = '0;
          for (int p = 0; p < nports; p++) act[p] = (p_op[p] != 2'b00);
          w = pick(act, nports, rr, m_ptr);
          if (w >= 0) begin
            m_win = w;
            m_wr = p_op[w][1];
            m_addr = p_addr[w];
            m_wdata = p_wdata[w];
            exp_rd = !m_wr;
            exp_wr = m_wr;
            m_ptr = (w + 1) % nports;
            grant_log.push_back(w);
            wait_left = (wait_cfg < 0) ? int'($urandom_range(3)) : wait_cfg;
            m_phase = 1;
          end
        end
        1: begin
          if (c_mem_ready) begin
            exp_ready = one << m_win;
            if (!m_wr) exp_rdata = c_mem_rdata;
            exp_rd = 1'b0;
            exp_wr = 1'b0;
            m_phase = 2;
          end
        end
        default: begin
          exp_ready = '0;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    #1;
    n_checks++;
    if ({fp_mem_rd, fp_mem_wr, fp_ready, fp_rdata, fp_mem_addr, fp_mem_wdata} !== 100'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_fp: got rd=%b wr=%b ready=%b rdata=%h addr=%h wdata=%h expected all zero",
               fp_mem_rd, fp_mem_wr, fp_ready, fp_rdata, fp_mem_addr, fp_mem_wdata);
    end
    n_checks++;
    if ({rr_mem_rd, rr_mem_wr, rr_ready, rr_rdata, rr_mem_addr, rr_mem_wdata} !== 102'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_rr: got rd=%b wr=%b ready=%b rdata=%h addr=%h wdata=%h expected all zero",
               rr_mem_rd, rr_mem_wr, rr_ready, rr_rdata, rr_mem_addr, rr_mem_wdata);
    end
  endtask

  task automatic test_single_read();
    $display("[TB] test_single_read");
    sel = 1'b0; nports = 2; rr = 1'b0;
    issue_mask = '0; issue_prob = 0; spurious = 1'b0;
    wait_cfg = 2; fixed_en = 1'b1; fixed_data = 32'hDEADBEEF;
    rd_high = 0; grant_log.delete();
    p_op[1] = 2'b01; p_addr[1] = 32'h100; p_wdata[1] = 32'h0;
    run(8);
    n_checks++;
    if (rd_high != 3) begin
      n_errors++;
      $display("[TB] FAIL read_strobe_len: got %0d cycles expected 3", rd_high);
    end
    n_checks++;
    if (s_rdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("[TB] FAIL read_data: got %h expected deadbeef", s_rdata);
    end
    n_checks++;
    if (grant_log.size() != 1 || grant_log[0] != 1) begin
      n_errors++;
      $display("[TB] FAIL read_grant: got %0d grants expected one grant to port 1", grant_log.size());
    end
  endtask

  task automatic test_write();
    $display("[TB] test_write");
    wait_cfg = 1; wr_high = 0; grant_log.delete();
    p_op[0] = 2'b10; p_addr[0] = 32'h40; p_wdata[0] = 32'h12345678;
    run(8);
    n_checks++;
    if (wr_high != 2) begin
      n_errors++;
      $display("[TB] FAIL write_strobe_len: got %0d cycles expected 2", wr_high);
    end
    n_checks++;
    if (s_rdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("[TB] FAIL write_keeps_rdata: got %h expected deadbeef", s_rdata);
    end
  endtask

  task automatic test_both_rd_wr();
    $display("[TB] test_both_rd_wr");
    wait_cfg = 0; rd_high = 0; wr_high = 0;
    p_op[0] = 2'b11; p_addr[0] = 32'h80; p_wdata[0] = 32'hCAFEF00D;
    run(6);
    n_checks++;
    if (rd_high != 0 || wr_high != 1) begin
      n_errors++;
      $display("[TB] FAIL both_is_write: got rd cycles=%0d wr cycles=%0d expected 0 and 1",
               rd_high, wr_high);
    end
  endtask

  task automatic test_fixed_priority();
    int zeros;
    $display("[TB] test_fixed_priority");
    do_reset();
    sel = 1'b0; nports = 2; rr = 1'b0; fixed_en = 1'b0;
    issue_mask = 4'b0011; issue_prob = 100; wait_cfg = -1;
    p_op[0] = 2'b01; p_op[1] = 2'b10;
    run(30);
    zeros = 0;
    foreach (grant_log[i]) if (grant_log[i] == 0) zeros++;
    n_checks++;
    if (grant_log.size() < 4 || zeros != grant_log.size()) begin
      n_errors++;
      $display("[TB] FAIL fixed_starve: got %0d grants, %0d to port 0, expected all to port 0",
               grant_log.size(), zeros);
    end
    grant_log.delete();
    issue_mask = 4'b0010;
    run(20);
    n_checks++;
    if (grant_log.size() < 2 || grant_log[grant_log.size()-1] != 1) begin
      n_errors++;
      $display("[TB] FAIL fixed_release: got %0d grants expected port 1 served after port 0 drops",
               grant_log.size());
    end
  endtask

  task automatic test_round_robin();
    $display("[TB] test_round_robin");
    do_reset();
    sel = 1'b1; nports = 4; rr = 1'b1; fixed_en = 1'b0;
    issue_mask = 4'b1111; issue_prob = 100; wait_cfg = -1;
    for (int p = 0; p < 4; p++) begin
      p_op[p] = 2'($urandom_range(1, 3));
      p_addr[p] = $urandom;
      p_wdata[p] = $urandom;
    end
    run(40);
    n_checks++;
    if (grant_log.size() < 5) begin
      n_errors++;
      $display("[TB] FAIL rr_count: got %0d grants expected at least 5", grant_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (grant_log[k] != k % 4) begin
          n_errors++;
          $display("[TB] FAIL rr_order: grant %0d got port %0d expected port %0d",
                   k, grant_log[k], k % 4);
        end
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    $display("[TB] test_reset_mid_busy");
    do_reset();
    sel = 1'b0; nports = 2; rr = 1'b0;
    issue_mask = '0; issue_prob = 0; wait_cfg = 10; spurious = 1'b0;
    p_op[0] = 2'b01; p_addr[0] = 32'h200;
    run(2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (fp_mem_rd !== 1'b0 || fp_mem_wr !== 1'b0 || fp_ready !== 2'b00) begin
      n_errors++;
      $display("[TB] FAIL reset_busy: got rd=%b wr=%b ready=%b expected all zero",
               fp_mem_rd, fp_mem_wr, fp_ready);
    end
    @(negedge clk);
    model_reset();
    drive_reqs();
    c_mem_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    c_mem_ready = 1'b1;
    c_mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    c_mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (fp_ready !== 2'b00 || fp_mem_rd !== 1'b0 || fp_rdata !== 32'h0) begin
        n_errors++;
        $display("[TB] FAIL late_ready: got ready=%b rd=%b rdata=%h expected 00 0 0",
                 fp_ready, fp_mem_rd, fp_rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    do_reset();
    sel = 1'b0; nports = 2; rr = 1'b0; fixed_en = 1'b0;
    issue_mask = 4'b0011; issue_prob = 40; wait_cfg = -1; spurious = 1'b1;
    run(300);
    do_reset();
    sel = 1'b1; nports = 4; rr = 1'b1;
    issue_mask = 4'b1111; issue_prob = 30;
    run(400);
    spurious = 1'b0;
  endtask

  initial begin
    model_reset();
    drive_reqs();
    test_reset();
    test_single_read();
    test_write();
    test_both_rd_wr();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
